// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM sequencing the multi-cycle RV32I datapath strobes, selects and memory handshakes
module multicycle_ctrl #(
  parameter int TO_W   = 4,
  parameter int TO_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_load,
  output logic       ir_load,
  output logic       a_load,
  output logic       b_load,
  output logic       aluout_load,
  output logic       mdr_load,
  output logic       rf_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic [1:0] wb_sel,
  output logic [3:0] state,
  output logic       mem_err
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_ALU = 4'd7,
    WB_MEM = 4'd8,
    BRANCH = 4'd9,
    JAL    = 4'd10,
    ERROR  = 4'd11
  } state_e;
  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            mem_st, stall, timeout, taken;
  logic            pc_load_c, ir_load_c, a_load_c, b_load_c, aluout_load_c, mdr_load_c;
  logic            rf_write_c, mem_read_c, mem_write_c;
  logic [1:0]      alu_src_a_c, alu_src_b_c, alu_op_c, pc_src_c, wb_sel_c;
  assign mem_st  = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  assign stall   = mem_st && !mem_ready;
  assign timeout = stall && (cnt_q == TO_W'(TO_MAX));
  assign taken   = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
  // state and wait-timeout registers; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state: opcode decode, memory waits, timeout escape, and trap for unused codes
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          7'b0110011: state_d = EXEC_R;
          7'b0010011: state_d = EXEC_I;
          7'b0000011: state_d = ADDR;
          7'b0100011: state_d = ADDR;
          7'b1100011: state_d = BRANCH;
          7'b1101111: state_d = JAL;
          default:    state_d = ERROR;
        endcase
      end
      EXEC_R: state_d = WB_ALU;
      EXEC_I: state_d = WB_ALU;
      ADDR:   state_d = opcode[5] ? MEM_WR : MEM_RD;
      MEM_RD: state_d = mem_ready ? WB_MEM : MEM_RD;
      MEM_WR: state_d = mem_ready ? FETCH : MEM_WR;
      WB_ALU: state_d = FETCH;
      WB_MEM: state_d = FETCH;
      BRANCH: state_d = FETCH;
      JAL:    state_d = FETCH;
      ERROR:  state_d = ERROR;
      default: state_d = ERROR;
    endcase
    if (timeout) state_d = ERROR;
    cnt_d = (state_d != state_q) ? '0 : stall ? cnt_q + 1'b1 : cnt_q;
  end
  // per-state datapath controls; the ready/taken qualified strobes are the only combinational paths
  always_comb begin
    pc_load_c     = 1'b0;
    ir_load_c     = 1'b0;
    a_load_c      = 1'b0;
    b_load_c      = 1'b0;
    aluout_load_c = 1'b0;
    mdr_load_c    = 1'b0;
    rf_write_c    = 1'b0;
    mem_read_c    = 1'b0;
    mem_write_c   = 1'b0;
    alu_src_a_c   = 2'b00;
    alu_src_b_c   = 2'b00;
    alu_op_c      = 2'b00;
    pc_src_c      = 2'b00;
    wb_sel_c      = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read_c  = 1'b1;
        alu_src_b_c = 2'b01;
        pc_load_c   = mem_ready;
        ir_load_c   = mem_ready;
      end
      DECODE: begin
        a_load_c      = 1'b1;
        b_load_c      = 1'b1;
        aluout_load_c = 1'b1;
        alu_src_a_c   = 2'b10;
        alu_src_b_c   = 2'b10;
      end
      EXEC_R: begin
        alu_src_a_c   = 2'b01;
        alu_op_c      = 2'b10;
        aluout_load_c = 1'b1;
      end
      EXEC_I: begin
        alu_src_a_c   = 2'b01;
        alu_src_b_c   = 2'b10;
        alu_op_c      = 2'b11;
        aluout_load_c = 1'b1;
      end
      ADDR: begin
        alu_src_a_c   = 2'b01;
        alu_src_b_c   = 2'b10;
        aluout_load_c = 1'b1;
      end
      MEM_RD: begin
        mem_read_c = 1'b1;
        mdr_load_c = mem_ready;
      end
      MEM_WR: mem_write_c = 1'b1;
      WB_ALU: rf_write_c = 1'b1;
      WB_MEM: begin
        rf_write_c = 1'b1;
        wb_sel_c   = 2'b01;
      end
      BRANCH: begin
        alu_src_a_c = 2'b01;
        alu_op_c    = 2'b01;
        pc_src_c    = 2'b01;
        pc_load_c   = taken;
      end
      JAL: begin
        rf_write_c = 1'b1;
        wb_sel_c   = 2'b10;
        pc_load_c  = 1'b1;
        pc_src_c   = 2'b01;
      end
      default: ;
    endcase
  end
  assign pc_load     = rst & pc_load_c;
  assign ir_load     = rst & ir_load_c;
  assign a_load      = rst & a_load_c;
  assign b_load      = rst & b_load_c;
  assign aluout_load = rst & aluout_load_c;
  assign mdr_load    = rst & mdr_load_c;
  assign rf_write    = rst & rf_write_c;
  assign mem_read    = rst & mem_read_c;
  assign mem_write   = rst & mem_write_c;
  assign alu_src_a   = rst ? alu_src_a_c : 2'b00;
  assign alu_src_b   = rst ? alu_src_b_c : 2'b00;
  assign alu_op      = rst ? alu_op_c : 2'b00;
  assign pc_src      = rst ? pc_src_c : 2'b00;
  assign wb_sel      = rst ? wb_sel_c : 2'b00;
  assign state       = state_q;
  assign mem_err     = (state_q == ERROR);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction-level checking of multicycle_ctrl against a per-class cycle model
module tb_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_load, ir_load, a_load, b_load, aluout_load, mdr_load;
  logic       rf_write, mem_read, mem_write, mem_err;
  logic [1:0] alu_src_a, alu_src_b, alu_op, pc_src, wb_sel;
  logic [3:0] state;
  int         total = 0;
  int         passes = 0;
  typedef struct packed {
    logic pc, ir, a, b, ao, mdr, rf, mr, mw;
    logic [1:0] sa, sb, op, ps, wb;
    logic err;
  } outs_t;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  logic [6:0] legal_ops [6] = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL};

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pc_load(pc_load), .ir_load(ir_load), .a_load(a_load), .b_load(b_load),
    .aluout_load(aluout_load), .mdr_load(mdr_load), .rf_write(rf_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .wb_sel(wb_sel), .state(state), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] r7();
    logic [31:0] r;
    r = $urandom;
    return r[6:0];
  endfunction

  function automatic logic [2:0] r3();
    logic [31:0] r;
    r = $urandom;
    return r[2:0];
  endfunction

  function automatic logic rb();
    logic [31:0] r;
    r = $urandom;
    return r[0];
  endfunction

  function automatic outs_t observed();
    outs_t o;
    o = {pc_load, ir_load, a_load, b_load, aluout_load, mdr_load, rf_write, mem_read, mem_write,
         alu_src_a, alu_src_b, alu_op, pc_src, wb_sel, mem_err};
    return o;
  endfunction

  // expected control word for one cycle of a given state, written from the state table
  function automatic outs_t exp_out(input int st, input logic rdy, input logic [2:0] f3, input logic z);
    outs_t o;
    o = '0;
    case (st)
      0:  begin o.mr = 1'b1; o.sb = 2'b01; o.pc = rdy; o.ir = rdy; end
      1:  begin o.a = 1'b1; o.b = 1'b1; o.ao = 1'b1; o.sa = 2'b10; o.sb = 2'b10; end
      2:  begin o.sa = 2'b01; o.op = 2'b10; o.ao = 1'b1; end
      3:  begin o.sa = 2'b01; o.sb = 2'b10; o.op = 2'b11; o.ao = 1'b1; end
      4:  begin o.sa = 2'b01; o.sb = 2'b10; o.ao = 1'b1; end
      5:  begin o.mr = 1'b1; o.mdr = rdy; end
      6:  o.mw = 1'b1;
      7:  o.rf = 1'b1;
      8:  begin o.rf = 1'b1; o.wb = 2'b01; end
      9:  begin o.sa = 2'b01; o.op = 2'b01; o.ps = 2'b01; o.pc = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0; end
      10: begin o.rf = 1'b1; o.wb = 2'b10; o.pc = 1'b1; o.ps = 2'b01; end
      11: o.err = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // one clock: drive inputs after the falling edge, compare state and controls before the rising edge
  task automatic step(input int es, input logic rdy, input logic [6:0] op, input logic [2:0] f3, input logic z);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = rdy;
    opcode = op;
    funct3 = f3;
    zero = z;
    #1;
    chk($sformatf("state(exp %0d)", es), 32'(state), 32'(es));
    chk($sformatf("ctrl@state%0d", es), 32'(observed()), 32'(exp_out(es, rdy, f3, z)));
  endtask

  task automatic idle_step(input int es, input logic rdy);
    step(es, rdy, r7(), r3(), rb());
  endtask

  // whole instruction: wf fetch wait cycles, wm data-memory wait cycles, then the class's state path
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic z, input int wf, input int wm);
    repeat (wf) idle_step(0, 1'b0);
    idle_step(0, 1'b1);
    step(1, rb(), op, r3(), rb());
    case (op)
      OP_R:  begin idle_step(2, rb()); idle_step(7, rb()); end
      OP_I:  begin idle_step(3, rb()); idle_step(7, rb()); end
      OP_LD: begin
        step(4, rb(), op, r3(), rb());
        repeat (wm) idle_step(5, 1'b0);
        idle_step(5, 1'b1);
        idle_step(8, rb());
      end
      OP_ST: begin
        step(4, rb(), op, r3(), rb());
        repeat (wm) idle_step(6, 1'b0);
        idle_step(6, 1'b1);
      end
      OP_BR:  step(9, rb(), r7(), f3, z);
      OP_JAL: idle_step(10, rb());
      default: idle_step(11, rb());
    endcase
  endtask

  // hold reset for n cycles; the next step() releases it at a falling edge
  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (i != 0) @(negedge clk);
      opcode = r7();
      #1;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_ctrl", 32'(observed()), 32'd0);
    end
  endtask

  initial begin
    do_reset(3);
    run_instr(OP_R, 3'd0, 1'b0, 0, 0);
    run_instr(OP_LD, 3'd2, 1'b0, 0, 3);
    run_instr(OP_BR, 3'd0, 1'b1, 0, 0);
    run_instr(OP_BR, 3'd0, 1'b0, 1, 0);
    run_instr(OP_BR, 3'd1, 1'b0, 0, 0);
    run_instr(OP_BR, 3'd1, 1'b1, 0, 0);
    run_instr(OP_ST, 3'd2, 1'b0, 2, 0);
    run_instr(OP_JAL, 3'd0, 1'b0, 0, 0);
    run_instr(OP_I, 3'd0, 1'b0, 15, 0);
    run_instr(OP_LD, 3'd0, 1'b0, 0, 15);
    run_instr(OP_ST, 3'd0, 1'b0, 0, 15);
    for (int i = 0; i < 60; i++)
      run_instr(legal_ops[$urandom_range(0, 5)], r3(), rb(), $urandom_range(0, 4), $urandom_range(0, 4));
    repeat (16) idle_step(0, 1'b0);
    repeat (4) idle_step(11, rb());
    do_reset(1);
    run_instr(OP_LD, 3'd0, 1'b0, 0, 0);
    idle_step(0, 1'b1);
    step(1, 1'b1, OP_LD, 3'd0, 1'b0);
    step(4, 1'b1, OP_LD, 3'd0, 1'b0);
    repeat (16) idle_step(5, 1'b0);
    idle_step(11, 1'b1);
    do_reset(1);
    run_instr(7'b1111111, 3'd0, 1'b0, 0, 0);
    repeat (3) idle_step(11, 1'b1);
    do_reset(2);
    idle_step(0, 1'b1);
    step(1, 1'b0, OP_ST, 3'd2, 1'b0);
    step(4, 1'b0, OP_ST, 3'd2, 1'b0);
    idle_step(6, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_mem_write", 32'(mem_write), 32'd0);
    chk("async_rst_ctrl", 32'(observed()), 32'd0);
    do_reset(2);
    run_instr(OP_R, 3'd0, 1'b0, 0, 0);
    for (int i = 0; i < 20; i++)
      run_instr(legal_ops[$urandom_range(0, 5)], r3(), rb(), $urandom_range(0, 2), $urandom_range(0, 2));
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences the multi-cycle RV32I datapath built from load-enabled registers (PC, IR, A, B, ALUOut, MDR) and the register file.
- Issues per-cycle load strobes, mux selects, ALU op class and memory handshakes.
- Decodes opcode/funct3 held in IR.
- Sits between the IR outputs and all datapath register `load` inputs.

Parameters:
- TO_W, 4, width of memory-wait timeout counter.
- TO_MAX, 15, number of consecutive not-ready cycles in a memory state before the block enters ERROR.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- opcode  input  7  IR[6:0]
- funct3  input  3  IR[14:12]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_load, ir_load, a_load, b_load, aluout_load, mdr_load  output  1 each  register load strobes
- rf_write  output  1  register-file write enable
- mem_read, mem_write  output  1 each  memory request, held until mem_ready
- alu_src_a  output  2  00=PC, 01=A, 10=OldPC
- alu_src_b  output  2  00=B, 01=const 4, 10=Imm
- alu_op  output  2  00=ADD, 01=SUB, 10=R-funct, 11=I-funct
- pc_src  output  2  00=ALU result, 01=ALUOut
- wb_sel  output  2  00=ALUOut, 01=MDR, 10=PC
- state  output  4  current state code (debug)
- mem_err  output  1  high while in ERROR

Behaviour:
- Reset:
  - rst=0 asynchronously forces state=FETCH(0), clears timeout counter and mem_err.
  - While rst=0, every strobe, mem_read and mem_write is 0 and all selects are 00.
  - Reset mid-instruction aborts it; no partial rf_write or mem_write is issued afterwards.
- Outputs are Moore (decoded from state), except these, which are combinational:
  - FETCH pc_load/ir_load = mem_ready.
  - MEM_RD mdr_load = mem_ready.
  - BRANCH pc_load = taken.
- Unlisted outputs are 0 / 00 in each state.
- State codes and transitions:
  - FETCH(0):
    - Outputs: mem_read=1, alu_src_a=00, alu_src_b=01, alu_op=00, pc_src=00.
    - mem_ready=1: pc_load=1, ir_load=1, next DECODE. Otherwise stay.
  - DECODE(1):
    - Outputs: a_load=1, b_load=1, alu_src_a=10, alu_src_b=10, alu_op=00, aluout_load=1 (branch/jump target precompute).
    - Next by opcode: 0110011->EXEC_R, 0010011->EXEC_I, 0000011/0100011->ADDR, 1100011->BRANCH, 1101111->JAL, any other->ERROR.
  - EXEC_R(2): alu_src_a=01, alu_src_b=00, alu_op=10, aluout_load=1 -> WB_ALU.
  - EXEC_I(3): alu_src_a=01, alu_src_b=10, alu_op=11, aluout_load=1 -> WB_ALU.
  - ADDR(4): alu_src_a=01, alu_src_b=10, alu_op=00, aluout_load=1 -> MEM_RD if opcode[5]=0, else MEM_WR.
  - MEM_RD(5): mem_read=1; mem_ready=1 -> WB_MEM.
  - MEM_WR(6): mem_write=1; mem_ready=1 -> FETCH.
  - WB_ALU(7): rf_write=1, wb_sel=00 -> FETCH.
  - WB_MEM(8): rf_write=1, wb_sel=01 -> FETCH.
  - BRANCH(9):
    - Outputs: alu_src_a=01, alu_src_b=00, alu_op=01, pc_src=01.
    - taken = (funct3==000 & zero) | (funct3==001 & ~zero); all other funct3 are not taken.
    - Next FETCH.
  - JAL(10): rf_write=1, wb_sel=10 (PC already holds PC+4), pc_load=1, pc_src=01 -> FETCH.
  - ERROR(11): all strobes 0, mem_err=1; sticky until rst=0.
- Latency with zero wait states: R/I/store = 4 cycles, load = 5, branch/JAL = 3.
- Timeout:
  - Counter clears on every state change.
  - In FETCH/MEM_RD/MEM_WR it increments each cycle mem_ready=0.
  - count==TO_MAX with mem_ready=0 -> ERROR next edge.
  - mem_ready=1 in the same cycle as count==TO_MAX wins: normal transition, no error.
- opcode/funct3 are sampled only in DECODE, ADDR and BRANCH; their values in other states are ignored.
- State codes 12-15 are unreachable; if entered, next state is ERROR.

Test Plan:
- rst=0 held 3 cycles while mem_ready=1 -> state=0, all strobes 0, mem_read=0; release -> mem_read=1 in cycle 1.
- mem_ready tied 1, opcode=0110011 -> state sequence 0,1,2,7,0; rf_write=1 only in state 7; pc_load/ir_load=1 only in state 0.
- Load (0000011), mem_ready=0 for 3 cycles in MEM_RD then 1 -> MEM_RD lasts 4 cycles; mdr_load=1 only on the ready cycle; then WB_MEM with wb_sel=01.
- BEQ (funct3=000) with zero=1 -> pc_load=1 in BRANCH. With zero=0 -> pc_load=0. BNE (001) with zero=0 -> pc_load=1.
- mem_ready=0 for 16 cycles in FETCH -> ERROR, mem_err=1 stays set. Repeat with mem_ready=1 at count 15 -> DECODE, no error. Opcode=1111111 -> ERROR after DECODE.
- rst asserted during MEM_WR with mem_ready=0 -> mem_write drops immediately; after release FETCH restarts; no write observed.
